// File: rtl/lsu_mem_master_if.sv
// Bundle of the core request/response handshake and the data-memory port of lsu_mem_master.
// The master modport is the LSU side; the slave modport is the core plus memory side.
interface lsu_mem_master_if #(
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_we;
  logic [3:0]            mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_wmask, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_wmask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator driving a word-addressed data memory with byte write masks.
// Define MISALIGN_SPLIT_EN to split misaligned H/W accesses into two memory cycles.
module lsu_mem_master #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_master_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           lo_buf_q;

  logic                  req_legal;
  logic                  req_err;
  logic [3:0]            base_mask;
  logic [7:0]            m64;
  logic [63:0]           d64;
  logic                  spans;

  logic                  unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

  function automatic logic [31:0] load_extend(input logic [63:0] raw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f);
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    req_legal = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_SPLIT_EN
    req_err = !req_legal;
`else
    req_err = !req_legal
            || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`endif
  end

  // Lane placement over a 64-bit window: the upper half belongs to the following word.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    m64   = {4'b0000, base_mask} << off_q;
    d64   = {32'b0, wdata_q} << {off_q, 3'b000};
    spans = |m64[7:4];
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_wmask = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ACC0: begin
        bus.mem_we    = we_q;
        bus.mem_wmask = m64[3:0];
        bus.mem_addr  = widx_q;
        bus.mem_wdata = d64[31:0];
      end
      ACC1: begin
        bus.mem_we    = we_q;
        bus.mem_wmask = m64[7:4];
        bus.mem_addr  = widx_q + ADDR_WIDTH'(1);
        bus.mem_wdata = d64[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      widx_q       <= '0;
      wdata_q      <= '0;
      lo_buf_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            off_q       <= bus.req_addr[1:0];
            widx_q      <= bus.req_addr[ADDR_WIDTH+1:2];
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ACC0;
            end
          end
        end
        ACC0: begin
          if (!we_q) lo_buf_q <= bus.mem_rdata;
          if (spans) begin
            state_q <= ACC1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : load_extend({32'b0, bus.mem_rdata}, off_q, funct3_q);
          end
        end
        // Upper word is consumed straight from the read port on the same edge it is captured.
        ACC1: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? '0 : load_extend({bus.mem_rdata, lo_buf_q}, off_q, funct3_q);
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: byte-level reference model plus literal pins.
// Honours MISALIGN_SPLIT_EN in the same way as the design.
module tb_lsu_mem_master;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_WIDTH(AW)) bif();
  lsu_mem_master #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.master));

  // Memory seen by the DUT; backdoor writes share the single write process.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  assign bif.mem_rdata = mem[bif.mem_addr];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bif.mem_we)
      for (int i = 0; i < 4; i++)
        if (bif.mem_wmask[i]) mem[bif.mem_addr][8*i+:8] <= bif.mem_wdata[8*i+:8];
  end

  typedef struct {
    logic          rv;
    logic          we;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          err;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("busy_ready", 32'(bif.req_ready), 32'd0);
        chk("mem_we", 32'(bif.mem_we), 32'(e.we));
        chk("mem_wmask", 32'(bif.mem_wmask), 32'(e.mask));
        chk("mem_addr", 32'(bif.mem_addr), 32'(e.addr));
        chk("mem_wdata", bif.mem_wdata, e.wdata);
        chk("resp_valid", 32'(bif.resp_valid), 32'(e.rv));
        if (e.rv) begin
          chk("resp_rdata", bif.resp_rdata, e.rdata);
          chk("resp_err", 32'(bif.resp_err), 32'(e.err));
        end
      end else begin
        chk("idle_ready", 32'(bif.req_ready), 32'd1);
        chk("idle_mem_we", 32'(bif.mem_we), 32'd0);
        chk("idle_wmask", 32'(bif.mem_wmask), 32'd0);
        chk("idle_resp_valid", 32'(bif.resp_valid), 32'd0);
      end
    end
  end

  // Reference: walk the access byte by byte and group bytes by the word they land in.
  task automatic model(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic legal, err;
    int off, n;
    logic [3:0] mk[2];
    logic [31:0] dw[2];
    logic [AW-1:0] wi[2];
    logic [31:0] val, r;
    off = int'(a[1:0]);
    n = 1 << f[1:0];
    legal = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal;
`ifndef MISALIGN_SPLIT_EN
    if (off % n != 0) err = 1'b1;
`endif
    if (err) begin
      e = '{rv: 1'b1, we: 1'b0, mask: '0, addr: '0, wdata: '0, rdata: '0, err: 1'b1};
      expq.push_back(e);
      return;
    end
    wi[0] = a[AW+1:2];
    wi[1] = wi[0] + 1'b1;
    mk[0] = '0; mk[1] = '0; dw[0] = '0; dw[1] = '0; val = '0;
    for (int k = 0; k < n; k++) begin
      int h, ln;
      h = (off + k) / 4;
      ln = (off + k) % 4;
      mk[h][ln] = 1'b1;
      dw[h][8*ln+:8] = wd[8*k+:8];
      val[8*k+:8] = ref_mem[wi[h]][8*ln+:8];
    end
    e = '{rv: 1'b0, we: we, mask: mk[0], addr: wi[0], wdata: dw[0], rdata: '0, err: 1'b0};
    expq.push_back(e);
    if (mk[1] != 4'b0000) begin
      e = '{rv: 1'b0, we: we, mask: mk[1], addr: wi[1], wdata: dw[1], rdata: '0, err: 1'b0};
      expq.push_back(e);
    end
    if (we) r = '0;
    else case (f)
      3'd0: r = {{24{val[7]}}, val[7:0]};
      3'd4: r = {24'b0, val[7:0]};
      3'd1: r = {{16{val[15]}}, val[15:0]};
      3'd5: r = {16'b0, val[15:0]};
      default: r = val;
    endcase
    e = '{rv: 1'b1, we: 1'b0, mask: '0, addr: '0, wdata: '0, rdata: r, err: 1'b0};
    expq.push_back(e);
    if (we)
      for (int k = 0; k < n; k++)
        ref_mem[wi[(off + k) / 4]][8*((off + k) % 4)+:8] = wd[8*k+:8];
  endtask

  task automatic setword(input logic [AW-1:0] w, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = w; bd_data = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[w] = v;
  endtask

  int            lat;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          s_we[2];
  logic [3:0]    s_mask[2];
  logic [AW-1:0] s_addr[2];
  logic [31:0]   s_wdata[2];
  logic [31:0]   tmp;

  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_funct3 = f;
    bif.req_addr = a; bif.req_wdata = wd;
    @(posedge clk);
    model(we, f, a, wd);
    #1 bif.req_valid = 1'b0;
    lat = 1;
    s_we[0] = bif.mem_we; s_mask[0] = bif.mem_wmask; s_addr[0] = bif.mem_addr; s_wdata[0] = bif.mem_wdata;
    s_we[1] = 1'b0; s_mask[1] = '0; s_addr[1] = '0; s_wdata[1] = '0;
    while (!bif.resp_valid && lat < 8) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 2) begin
        s_we[1] = bif.mem_we; s_mask[1] = bif.mem_wmask; s_addr[1] = bif.mem_addr; s_wdata[1] = bif.mem_wdata;
      end
    end
    if (!bif.resp_valid) chk("resp_timeout", 32'(bif.resp_valid), 32'd1);
    r_rdata = bif.resp_rdata;
    r_err = bif.resp_err;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_funct3 = '0;
    bif.req_addr = '0; bif.req_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    chk("rst_resp_rdata", bif.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bif.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
    chk("rst_wmask", 32'(bif.mem_wmask), 32'd0);
    chk("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
    chk("rst_mem_wdata", bif.mem_wdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) setword(AW'(i), 32'h0);
    setword(AW'((1 << AW) - 1), 32'h0);
    cmp_en = 1'b1;

    issue(1'b1, 3'd0, 32'h6, 32'h0000_00A5);
    chk("sb_latency", 32'(lat), 32'd2);
    chk("sb_we", 32'(s_we[0]), 32'd1);
    chk("sb_mask", 32'(s_mask[0]), 32'b0100);
    chk("sb_addr", 32'(s_addr[0]), 32'd1);
    tmp = s_wdata[0];
    chk("sb_lane2", 32'(tmp[23:16]), 32'hA5);
    chk("sb_err", 32'(r_err), 32'd0);

    setword(AW'(1), 32'h80FF_1234);
    issue(1'b0, 3'd0, 32'h7, 32'h0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'd4, 32'h7, 32'h0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);
    issue(1'b0, 3'd1, 32'h6, 32'h0);
    chk("lh_rdata", r_rdata, 32'hFFFF_80FF);
    issue(1'b0, 3'd5, 32'h6, 32'h0);
    chk("lhu_rdata", r_rdata, 32'h0000_80FF);
    issue(1'b0, 3'd2, 32'hFFFF_0004, 32'h0);
    chk("lw_hiaddr_rdata", r_rdata, 32'h80FF_1234);
    chk("lw_hiaddr_addr", 32'(s_addr[0]), 32'd1);
    issue(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h8, 32'h0);
    chk("sw_lw_rdata", r_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 3'd1, 32'hA, 32'h1234_CAFE);
    issue(1'b0, 3'd2, 32'h8, 32'h0);
    chk("sh_lw_rdata", r_rdata, 32'hCAFE_BEEF);

    setword(AW'(0), 32'h4433_2211);
    setword(AW'(1), 32'h8877_6655);
    issue(1'b0, 3'd2, 32'h1, 32'h0);
`ifdef MISALIGN_SPLIT_EN
    chk("split_lw_rdata", r_rdata, 32'h5544_3322);
    chk("split_lw_latency", 32'(lat), 32'd3);
    chk("split_lw_addr0", 32'(s_addr[0]), 32'd0);
    chk("split_lw_addr1", 32'(s_addr[1]), 32'd1);
`else
    chk("mis_lw_err", 32'(r_err), 32'd1);
    chk("mis_lw_latency", 32'(lat), 32'd1);
`endif
    issue(1'b1, 3'd1, 32'h3, 32'h0000_BEEF);
`ifdef MISALIGN_SPLIT_EN
    chk("split_sh_latency", 32'(lat), 32'd3);
    chk("split_sh_mask0", 32'(s_mask[0]), 32'b1000);
    tmp = s_wdata[0];
    chk("split_sh_lane3", 32'(tmp[31:24]), 32'hEF);
    chk("split_sh_addr1", 32'(s_addr[1]), 32'd1);
    chk("split_sh_mask1", 32'(s_mask[1]), 32'b0001);
    tmp = s_wdata[1];
    chk("split_sh_lane0", 32'(tmp[7:0]), 32'hBE);
    setword(AW'((1 << AW) - 1), 32'hAABB_CCDD);
    issue(1'b0, 3'd2, 32'(((1 << AW) - 1) * 4 + 2), 32'h0);
    chk("wrap_lw_rdata", r_rdata, 32'h2211_AABB);
    chk("wrap_lw_addr1", 32'(s_addr[1]), 32'd0);
`else
    chk("mis_sh_err", 32'(r_err), 32'd1);
    chk("mis_sh_latency", 32'(lat), 32'd1);
    chk("mis_sh_we", 32'(s_we[0]), 32'd0);
    issue(1'b0, 3'd5, 32'h1, 32'h0);
    chk("mis_lhu_err", 32'(r_err), 32'd1);
`endif

    setword(AW'(0), 32'h4433_2211);
    issue(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF);
    chk("ill_st_err", 32'(r_err), 32'd1);
    chk("ill_st_rdata", r_rdata, 32'd0);
    chk("ill_st_latency", 32'(lat), 32'd1);
    chk("ill_st_we", 32'(s_we[0]), 32'd0);
    issue(1'b0, 3'd2, 32'h0, 32'h0);
    chk("after_ill_lw", r_rdata, 32'h4433_2211);
    issue(1'b1, 3'd4, 32'h0, 32'h0);
    issue(1'b0, 3'd3, 32'h0, 32'h0);
    issue(1'b0, 3'd6, 32'h4, 32'h0);
    issue(1'b0, 3'd7, 32'h4, 32'h0);

    // Reset while a store is being driven onto the memory port.
    @(negedge clk);
    cmp_en = 1'b0;
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_funct3 = 3'd2;
    bif.req_addr = 32'h0; bif.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
    chk("rst_mid_we_before", 32'(bif.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_drop", 32'(bif.mem_we), 32'd0);
    chk("rst_mid_wmask", 32'(bif.mem_wmask), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_rel_resp_valid", 32'(bif.resp_valid), 32'd0);
    expq.delete();
    cmp_en = 1'b1;
    issue(1'b0, 3'd2, 32'h0, 32'h0);
    chk("rst_store_abandoned", r_rdata, 32'h4433_2211);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data memory port: `we`, 4-bit byte write mask, word address, write data, and a combinational read.
- Accepts one byte-addressed RV32I load/store request from the core per handshake.
- Computes byte lanes, write masks and store-data alignment; extracts and sign/zero-extends load data.
- Sits between the core's memory stage and the data memory. Accesses that cross a word boundary are split into two memory cycles when the optional feature is enabled.

Parameters:
- ADDR_WIDTH, 13, width of the memory word address; memory holds 2**ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  32  load result, extended; 0 for stores and errors
- resp_err  output  1  qualified by resp_valid: illegal or unsupported access
- mem_we  output  1  memory write enable
- mem_wmask  output  4  byte lane write mask, bit i = bits [8i+7:8i]
- mem_addr  output  ADDR_WIDTH  memory word address
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- Reset (async, rst_n low): state = IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_wmask=0; mem_addr=0; mem_wdata=0. A write in progress is abandoned and mem_we drops immediately.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - The request is accepted on the rising edge where req_valid && req_ready. All request fields are latched on that edge.
  - Let off = req_addr[1:0] and widx = req_addr[ADDR_WIDTH+1:2].
- Error check at acceptance; on error go to RESP with resp_err=1:
  - Store funct3 not in {000, 001, 010}.
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Misaligned access without MISALIGN_SPLIT_EN.
  - Error requests never produce a memory access and never assert mem_we.
- Otherwise go to ACC0.
- Lane computation:
  - base mask = 0001 (B), 0011 (H), 1111 (W).
  - m64 = base << off (8 bits); d64 = wdata << (8*off) (64 bits).
  - The access spans two words when m64[7:4] != 0.
- ACC0:
  - mem_addr = widx; mem_wmask = m64[3:0]; mem_wdata = d64[31:0].
  - mem_we = req_we. These signals are decoded from state and latched fields.
  - Loads capture mem_rdata into lo_buf at the edge.
  - Next state is ACC1 if the access spans two words, else RESP.
- ACC1:
  - mem_addr = widx+1, wrapping modulo 2**ADDR_WIDTH; mem_wmask = m64[7:4]; mem_wdata = d64[63:32].
  - mem_we = req_we. Loads capture mem_rdata into hi_buf. Next state is RESP.
- Outside ACC0/ACC1: mem_we=0 and mem_wmask=0; mem_addr and mem_wdata are 0.
- Load result: sh = {hi_buf, lo_buf} >> (8*off).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: sh[31:0].
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_err are registered and held until the next RESP. req_ready=0. Next state is IDLE.
- Latency, with acceptance at edge T:
  - Aligned access: ACC0 in cycle T+1, resp_valid in T+2.
  - Split access: resp_valid in T+3.
  - Error: resp_valid in T+1.
- Throughput: no new request is accepted until back in IDLE. resp_valid has no backpressure.
- req_addr bits above ADDR_WIDTH+1 are ignored.

Optional Feature:
- MISALIGN_SPLIT_EN defined: misaligned H/W accesses (including halfword at off=3 and word at off≠0) are split into ACC0+ACC1 as above. An access at the last word wraps to word 0.
- MISALIGN_SPLIT_EN undefined:
  - Any H/W access with a nonzero required-alignment remainder (H: off[0]=1; W: off≠0) returns resp_err=1 with no memory access.
  - ACC1 is never entered and may be omitted.

Test Plan:
- Reset mid-store: assert rst_n=0 while in ACC0 with mem_we=1 -> mem_we=0 immediately. After release, req_ready=1 and resp_valid=0.
- SB: addr 0x0000_0006, wdata 0x0000_00A5 -> ACC0: mem_addr=1, mem_wmask=0100, mem_wdata[23:16]=A5, mem_we=1. resp_valid 2 cycles after accept, resp_err=0.
- LB/LBU: memory word 1 = 0x80FF_1234, load at addr 0x7 -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- Split LW (feature on): word0=0x4433_2211, word1=0x8877_6655, LW at addr 0x1 -> ACC0 addr 0 then ACC1 addr 1. resp_rdata=0x5544_3322 three cycles after accept.
- Split SH (feature on): addr 0x3, wdata 0xBEEF -> ACC0 mask 1000 with lane3=EF; ACC1 addr 1, mask 0001, lane0=BE. With feature off, the same request gives resp_err=1, mem_we never asserted, and resp_valid 1 cycle after accept.
- Illegal funct3=011 store -> resp_err=1, resp_rdata=0, no memory access. Then an immediate LW at 0x0 is accepted and returns 0x4433_2211.
